// File: rtl/msrv32_pkg.sv
// msrv32 shared definitions.
// ALU opcode map, datapath width and small helpers.
package msrv32_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic [XLEN-1:0] bitrev(
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = d[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/msrv32_alu_shifter.sv
// msrv32 barrel shifter.
// Left shifts reuse the right-shift network on bit-reversed data.
module msrv32_alu_shifter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_in,
  input  logic [4:0]      shamt_in,
  input  logic            left_in,
  input  logic            arith_in,
  output logic [XLEN-1:0] data_out
);
  import msrv32_pkg::*;

  logic [XLEN-1:0] pre;
  logic [XLEN-1:0] st;
  logic [XLEN-1:0] mask;
  logic            fill;

  // five log stages, each shifting right by 2^i with sign/zero fill
  always_comb begin
    pre  = left_in ? bitrev(data_in) : data_in;
    fill = arith_in & ~left_in & data_in[XLEN-1];
    st   = pre;
    mask = '0;
    for (int i = 0; i < 5; i++) begin
      if (shamt_in[i]) begin
        mask = ~({XLEN{1'b1}} >> (1 << i));
        st   = st >> (1 << i);
        if (fill) begin
          st = st | mask;
        end
      end
    end
    data_out = left_in ? bitrev(st) : st;
  end

endmodule

// File: rtl/msrv32_alu.sv
// msrv32 RV32I integer ALU.
// Combinational result plus a registered copy.
module msrv32_alu #(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [3:0]      opcode_in,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] result_reg_out,
  output logic            zero_out
);
  import msrv32_pkg::*;

  logic [2:0]      f3;
  logic            f7;
  logic            is_add;
  logic            is_sub;
  logic            is_sll;
  logic            is_slt;
  logic            is_sltu;
  logic            is_xor;
  logic            is_srl;
  logic            is_sra;
  logic            is_or;
  logic            is_and;
  logic [XLEN-1:0] sum;
  logic [XLEN:0]   diff;
  logic            lt_u;
  logic            lt_s;
  logic [XLEN-1:0] shifted;
  logic            sh_left;
  logic            sh_arith;

  assign f3 = opcode_in[2:0];
  assign f7 = opcode_in[3];

  // one-hot decode; bit 3 only matters for add/sub and srl/sra
  always_comb begin
    is_add  = (f3 == F3_ADD) & ~f7;
    is_sub  = (f3 == F3_ADD) &  f7;
    is_sll  = (f3 == F3_SLL);
    is_slt  = (f3 == F3_SLT);
    is_sltu = (f3 == F3_SLTU);
    is_xor  = (f3 == F3_XOR);
    is_srl  = (f3 == F3_SR) & ~f7;
    is_sra  = (f3 == F3_SR) &  f7;
    is_or   = (f3 == F3_OR);
    is_and  = (f3 == F3_AND);
  end

  // one 33-bit subtract serves SUB, SLT and SLTU
  always_comb begin
    sum  = op_1_in + op_2_in;
    diff = {1'b0, op_1_in} - {1'b0, op_2_in};
    lt_u = diff[XLEN];
    if (op_1_in[XLEN-1] != op_2_in[XLEN-1]) begin
      lt_s = op_1_in[XLEN-1];
    end else begin
      lt_s = diff[XLEN-1];
    end
  end

  assign sh_left  = is_sll;
  assign sh_arith = is_sra;

  msrv32_alu_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .data_in  (op_1_in),
    .shamt_in (op_2_in[4:0]),
    .left_in  (sh_left),
    .arith_in (sh_arith),
    .data_out (shifted)
  );

  // result select
  always_comb begin
    result_out = '0;
    unique case (1'b1)
      is_add:  result_out = sum;
      is_sub:  result_out = diff[XLEN-1:0];
      is_sll:  result_out = shifted;
      is_slt:  result_out = {{(XLEN-1){1'b0}}, lt_s};
      is_sltu: result_out = {{(XLEN-1){1'b0}}, lt_u};
      is_xor:  result_out = op_1_in ^ op_2_in;
      is_srl:  result_out = shifted;
      is_sra:  result_out = shifted;
      is_or:   result_out = op_1_in | op_2_in;
      is_and:  result_out = op_1_in & op_2_in;
      default: result_out = '0;
    endcase
  end

  assign zero_out = (result_out == '0);

  // registered copy, cleared asynchronously while reset is low
  always_ff @(posedge ms_riscv32_mp_clk_in
              or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      result_reg_out <= '0;
    end else begin
      result_reg_out <= result_out;
    end
  end

endmodule

// File: tb/tb_msrv32_alu.sv
// msrv32_alu testbench.
// Directed and random vectors against a behavioural model.
module tb_msrv32_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] res;
  logic [31:0] res_reg;
  logic        zero;

  int vectors;
  int miscompares;

  msrv32_alu dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .op_1_in              (a),
    .op_2_in              (b),
    .opcode_in            (op),
    .result_out           (res),
    .result_reg_out       (res_reg),
    .zero_out             (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [3:0]  o
  );
    int unsigned sh;
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic [31:0] r;
    sh = int'(y % 32);
    sx = x;
    sy = y;
    r  = 32'd0;
    case (o[2:0])
      3'd0: if (o[3]) r = x - y; else r = x + y;
      3'd1: r = x << sh;
      3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (o[3]) begin
          sx = sx >>> sh;
          r  = sx;
        end else begin
          r = x >> sh;
        end
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(
    input string       tag,
    input logic [31:0] exp
  );
    chk({tag, " result"}, res, exp);
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[$];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] e;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a  = 32'd5;
    b  = 32'd3;
    op = 4'b0000;

    dir.push_back('{32'd5, 32'd3, 4'b0000, 32'd8});
    dir.push_back('{32'd5, 32'd3, 4'b1000, 32'd2});
    dir.push_back('{32'd3, 32'd3, 4'b1000, 32'd0});
    dir.push_back('{32'h7FFFFFFF, 32'd1, 4'b0000, 32'h80000000});
    dir.push_back('{32'd16, 32'd3, 4'b0101, 32'd2});
    dir.push_back('{32'h80000000, 32'd4, 4'b1101, 32'hF8000000});
    dir.push_back('{32'h80000000, 32'd4, 4'b0101, 32'h08000000});
    dir.push_back('{32'd1, 32'h25, 4'b0001, 32'h20});
    dir.push_back('{32'd1, 32'h25, 4'b1001, 32'h20});
    dir.push_back('{32'hFFFFFFFF, 32'd1, 4'b0010, 32'd1});
    dir.push_back('{32'hFFFFFFFF, 32'd1, 4'b0011, 32'd0});
    dir.push_back('{32'd7, 32'd7, 4'b0010, 32'd0});
    dir.push_back('{32'h80000000, 32'h7FFFFFFF, 4'b0010, 32'd1});
    dir.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'h0FF00FF0});
    dir.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 4'b0110, 32'hFFF0FFF0});
    dir.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 4'b0111, 32'hF000F000});
    dir.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 4'b1111, 32'hF000F000});
    dir.push_back('{32'hDEADBEEF, 32'd0, 4'b0001, 32'hDEADBEEF});
    dir.push_back('{32'hDEADBEEF, 32'd0, 4'b0101, 32'hDEADBEEF});
    dir.push_back('{32'hDEADBEEF, 32'd32, 4'b1101, 32'hDEADBEEF});
    dir.push_back('{32'h80000001, 32'hFFFFFFE1, 4'b1101, 32'hC0000000});

    #2;
    chk("reset reg t0", res_reg, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset reg held", res_reg, 32'd0);

    // combinational path works with reset low
    foreach (dir[i]) begin
      @(negedge clk);
      a  = dir[i].a;
      b  = dir[i].b;
      op = dir[i].op;
      #1;
      chk_comb($sformatf("dir%0d", i), dir[i].exp);
      chk($sformatf("dir%0d reg in rst", i), res_reg, 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    a  = 32'd5;
    b  = 32'd3;
    op = 4'b0000;
    #1;
    chk("post release reg", res_reg, 32'd0);
    @(posedge clk);
    #1;
    chk("first capture", res_reg, 32'd8);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      a  = pick();
      b  = pick();
      op = 4'($urandom_range(0, 15));
      e  = model(a, b, op);
      #1;
      chk_comb($sformatf("rnd%0d op%b", n, op), e);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d reg", n), res_reg, e);
    end

    // async reset between edges
    @(negedge clk);
    a  = 32'h1234_5678;
    b  = 32'h0000_0001;
    op = 4'b0000;
    @(posedge clk);
    #1;
    chk("pre async reg", res_reg, 32'h1234_5679);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async clear", res_reg, 32'd0);
    chk_comb("comb in rst", 32'h1234_5679);
    @(posedge clk);
    #1;
    chk("async held", res_reg, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid release", res_reg, 32'd0);
    @(posedge clk);
    #1;
    chk("mid release cap", res_reg, 32'h1234_5679);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msrv32_alu.md
Name: msrv32_alu

Overview:
- RV32I integer ALU for the msrv32 execute stage.
- Computes one of the ten RV32I register/immediate ALU operations on two 32-bit operands, selected by a 4-bit opcode of the form {funct7[5], funct3}.
- Provides a combinational result for same-cycle writeback muxing.
- Provides a registered copy of the result for pipelined consumers.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising-edge.
- ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low.
- op_1_in  input  32  operand A (rs1 or PC).
- op_2_in  input  32  operand B (rs2 or immediate); bits [4:0] are the shift amount for shifts.
- opcode_in  input  4  {funct7[5], funct3} operation select.
- result_out  output  32  combinational ALU result.
- result_reg_out  output  32  result_out registered on the clock.
- zero_out  output  1  combinational; 1 when result_out == 0.

Behaviour:
- Interface: one clock (ms_riscv32_mp_clk_in); reset (ms_riscv32_mp_rst_in) is asynchronous and active-low.
- result_out is purely combinational from op_1_in, op_2_in and opcode_in, with zero latency. It must be valid without any clock edge and is independent of reset.
- Opcode map:
  - 0000 ADD: A+B, modulo 2^32, carry discarded.
  - 1000 SUB: A-B, modulo 2^32.
  - 0001 SLL: A << B[4:0].
  - 0010 SLT: 32'd1 if signed(A) < signed(B), else 0.
  - 0011 SLTU: 32'd1 if unsigned A < unsigned B, else 0.
  - 0100 XOR: A^B.
  - 0101 SRL: A >> B[4:0], zero fill.
  - 1101 SRA: A >>> B[4:0], sign fill from A[31].
  - 0110 OR: A|B.
  - 0111 AND: A&B.
- Remaining codes (1001, 1010, 1011, 1100, 1110, 1111): bit 3 is ignored and the funct3 operation is performed. Example: 1111 gives AND, 1001 gives SLL.
- Shifts use only B[4:0]; B[31:5] is ignored. A shift amount of 0 returns A unchanged.
- Overflow never traps and raises no flag. Wrap-around is required, e.g. 0x7FFFFFFF+1 = 0x80000000.
- zero_out = (result_out == 32'd0), combinational.
- result_reg_out:
  - While ms_riscv32_mp_rst_in is low, it is forced to 32'd0 immediately, asynchronously.
  - On each rising clock edge with reset high, it loads result_out.
  - Reset deasserting mid-operation: the first capture happens at the first rising edge after deassertion.
- No X propagation for defined inputs. Every opcode value yields a defined result.

Decomposition:
- Shared package msrv32_pkg holds:
  - 4-bit localparams ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND.
  - The XLEN constant.
- One sub-module is natural: msrv32_alu_shifter, a 32-bit barrel shifter (inputs: data, shamt[4:0], direction, arithmetic; output: shifted data), used for SLL/SRL/SRA.
- Add/sub and the comparisons stay in the top module. SLT/SLTU derive from a single 33-bit subtraction.

Test Plan:
- ADD/SUB: A=5, B=3, op 0000 -> 8, zero_out=0. Op 1000 -> 2. A=3, B=3, op 1000 -> 0, zero_out=1. A=0x7FFFFFFF, B=1, op 0000 -> 0x80000000.
- Shifts:
  - A=16, B=3, op 0101 -> 2.
  - A=0x80000000, B=4, op 1101 -> 0xF8000000; op 0101 -> 0x08000000.
  - A=1, B=0x25 (shamt 5), op 0001 -> 0x20.
  - B=0 with any shift op -> A unchanged.
- Compares:
  - A=0xFFFFFFFF, B=1, op 0010 -> 1; op 0011 -> 0.
  - A=B=7, op 0010 -> 0.
  - A=0x80000000, B=0x7FFFFFFF, op 0010 -> 1.
- Logic, with A=0xF0F0F0F0, B=0xFF00FF00:
  - op 0100 -> 0x0FF00FF0.
  - op 0110 -> 0xFFF0FFF0.
  - op 0111 -> 0xF000F000.
  - op 1111 -> 0xF000F000.
- Register/reset:
  - With reset low, result_reg_out = 0 regardless of clock.
  - Release reset; A=5, B=3, op 0000; after one rising edge result_reg_out = 8.
  - Assert reset asynchronously between edges -> result_reg_out = 0 at once.
